// File: rtl/demux_strobe_gen_if.sv
// Request/strobe bundle between the microsequencer request logic and the
// 74x138 unit-select decoder. The master drives the request; the slave
// (demux_strobe_gen) drives status and the demux control lines.
interface demux_strobe_gen_if;
    logic       req;
    logic [2:0] addr;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic [2:0] a;
    logic       g1;
    logic       g2a_n;
    logic       g2b_n;

    modport master (
        output req, addr, count,
        input  busy, done, a, g1, g2a_n, g2b_n
    );

    modport slave (
        input  req, addr, count,
        output busy, done, a, g1, g2a_n, g2b_n
    );
endinterface

// File: rtl/demux_strobe_gen.sv
// Strobe generator for a 74x138-style 3-to-8 demux. Registers a unit address
// and sequences address/enables with SETUP, WIDTH and HOLD cycles so the demux
// produces a clean active-low select pulse.
// Optional feature macro: DEMUX_STROBE_BURST_EN (count+1 strobes to
// consecutive addresses). Undefined: one strobe per request.
module demux_strobe_gen #(
    parameter int unsigned SETUP = 1,  // 1..255
    parameter int unsigned WIDTH = 2,  // 1..255
    parameter int unsigned HOLD  = 1   // 1..255
) (
    input logic               clk,
    input logic               reset,
    demux_strobe_gen_if.slave bus
);

    localparam logic [7:0] SetupLast = 8'(SETUP - 1);
    localparam logic [7:0] WidthLast = 8'(WIDTH - 1);
    localparam logic [7:0] HoldLast  = 8'(HOLD - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e     state_q;
    logic [7:0] timer_q;
    logic [2:0] a_q;
    logic       busy_q;
    logic       done_q;
    logic       g1_q;
    logic       g2a_n_q;
    logic       g2b_n_q;

`ifdef DEMUX_STROBE_BURST_EN
    logic [2:0] burst_q;
`else
    logic unused_count;
    assign unused_count = ^bus.count;
`endif

    // Sequencer: state, phase timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= 8'd0;
            a_q     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g1_q    <= 1'b0;
            g2a_n_q <= 1'b1;
            g2b_n_q <= 1'b1;
`ifdef DEMUX_STROBE_BURST_EN
            burst_q <= 3'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // busy_q is 0 here, so a req in the done cycle is taken
                    if (bus.req) begin
                        a_q     <= bus.addr;
                        busy_q  <= 1'b1;
                        timer_q <= SetupLast;
                        state_q <= StSetup;
`ifdef DEMUX_STROBE_BURST_EN
                        burst_q <= bus.count;
`endif
                    end
                end
                StSetup: begin
                    if (timer_q == 8'd0) begin
                        g1_q    <= 1'b1;
                        g2a_n_q <= 1'b0;
                        g2b_n_q <= 1'b0;
                        timer_q <= WidthLast;
                        state_q <= StStrobe;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                StStrobe: begin
                    if (timer_q == 8'd0) begin
                        g1_q    <= 1'b0;
                        g2a_n_q <= 1'b1;
                        g2b_n_q <= 1'b1;
                        timer_q <= HoldLast;
                        state_q <= StHold;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                StHold: begin
                    if (timer_q == 8'd0) begin
`ifdef DEMUX_STROBE_BURST_EN
                        if (burst_q != 3'd0) begin
                            // next address only after enables are already off
                            burst_q <= burst_q - 3'd1;
                            a_q     <= a_q + 3'd1;
                            timer_q <= SetupLast;
                            state_q <= StSetup;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
`endif
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.a     = a_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.g1    = g1_q;
    assign bus.g2a_n = g2a_n_q;
    assign bus.g2b_n = g2b_n_q;

endmodule

// File: tb/tb_demux_strobe_gen.sv
// Directed bench for demux_strobe_gen with a 74x138 model on the outputs.
// Default parameters SETUP=1, WIDTH=2, HOLD=1.
module tb_demux_strobe_gen;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    demux_strobe_gen_if bus ();

    demux_strobe_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 74x138 model: active-low output selected only when fully enabled
    logic [7:0] y;
    assign y = (bus.g1 && !bus.g2a_n && !bus.g2b_n) ? ~(8'd1 << bus.a) : 8'hFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and check every output; en=1 means strobe on.
    task automatic step(input string tag, input logic [2:0] ea, input logic en,
                        input logic eb, input logic ed, input logic [7:0] ey);
        @(negedge clk);
        chk({tag, ".a"}, {5'd0, bus.a}, {5'd0, ea});
        chk({tag, ".en"}, {5'd0, bus.g1, bus.g2a_n, bus.g2b_n},
            en ? 8'b100 : 8'b011);
        chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, eb});
        chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, ed});
        chk({tag, ".y"}, y, ey);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.req   = 1'b1;
        bus.addr  = 3'd7;
        bus.count = 3'd7;

        // Reset held 3 cycles with req high
        step("rst0", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step("rst1", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step("rst2", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);

        // Single strobe, addr=5
        reset     = 1'b0;
        bus.req   = 1'b1;
        bus.addr  = 3'd5;
        bus.count = 3'd0;
        step("s1", 3'd5, 1'b0, 1'b1, 1'b0, 8'hFF);
        // Request during busy must be ignored
        bus.req  = 1'b1;
        bus.addr = 3'd2;
        step("s2", 3'd5, 1'b1, 1'b1, 1'b0, 8'hDF);
        step("s3", 3'd5, 1'b1, 1'b1, 1'b0, 8'hDF);
        step("s4", 3'd5, 1'b0, 1'b1, 1'b0, 8'hFF);
        step("s5", 3'd5, 1'b0, 1'b0, 1'b1, 8'hFF);
        // Back-to-back request in the done cycle
        bus.addr = 3'd6;
        step("b1", 3'd6, 1'b0, 1'b1, 1'b0, 8'hFF);
        bus.req = 1'b0;
        step("b2", 3'd6, 1'b1, 1'b1, 1'b0, 8'hBF);
        step("b3", 3'd6, 1'b1, 1'b1, 1'b0, 8'hBF);
        step("b4", 3'd6, 1'b0, 1'b1, 1'b0, 8'hFF);
        step("b5", 3'd6, 1'b0, 1'b0, 1'b1, 8'hFF);
        step("idle", 3'd6, 1'b0, 1'b0, 1'b0, 8'hFF);

`ifdef DEMUX_STROBE_BURST_EN
        // Burst of 3 from addr 6 with wrap: y[6], y[7], y[0]
        begin
            logic [2:0] ba [3];
            logic [7:0] by [3];
            ba = '{3'd6, 3'd7, 3'd0};
            by = '{8'hBF, 8'h7F, 8'hFE};
            bus.req   = 1'b1;
            bus.addr  = 3'd6;
            bus.count = 3'd2;
            for (int i = 0; i < 3; i++) begin
                step("burst.setup", ba[i], 1'b0, 1'b1, 1'b0, 8'hFF);
                bus.req = 1'b0;
                step("burst.on0", ba[i], 1'b1, 1'b1, 1'b0, by[i]);
                step("burst.on1", ba[i], 1'b1, 1'b1, 1'b0, by[i]);
                step("burst.hold", ba[i], 1'b0, 1'b1, 1'b0, 8'hFF);
            end
            step("burst.done", 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF);
            step("burst.idle", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        end
`else
        // count ignored: one strobe on y[3]
        bus.req   = 1'b1;
        bus.addr  = 3'd3;
        bus.count = 3'd7;
        step("nb1", 3'd3, 1'b0, 1'b1, 1'b0, 8'hFF);
        bus.req = 1'b0;
        step("nb2", 3'd3, 1'b1, 1'b1, 1'b0, 8'hF7);
        step("nb3", 3'd3, 1'b1, 1'b1, 1'b0, 8'hF7);
        step("nb4", 3'd3, 1'b0, 1'b1, 1'b0, 8'hFF);
        step("nb5", 3'd3, 1'b0, 1'b0, 1'b1, 8'hFF);
        step("nb6", 3'd3, 1'b0, 1'b0, 1'b0, 8'hFF);
`endif

        // Abort in second strobe cycle
        bus.req   = 1'b1;
        bus.addr  = 3'd4;
        bus.count = 3'd0;
        step("ab1", 3'd4, 1'b0, 1'b1, 1'b0, 8'hFF);
        bus.req = 1'b0;
        step("ab2", 3'd4, 1'b1, 1'b1, 1'b0, 8'hEF);
        step("ab3", 3'd4, 1'b1, 1'b1, 1'b0, 8'hEF);
        reset = 1'b1;
        step("ab4", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        reset = 1'b0;
        step("ab5", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step("ab6", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);

        // Fresh single strobe after abort, addr=1
        bus.req  = 1'b1;
        bus.addr = 3'd1;
        step("f1", 3'd1, 1'b0, 1'b1, 1'b0, 8'hFF);
        bus.req = 1'b0;
        step("f2", 3'd1, 1'b1, 1'b1, 1'b0, 8'hFD);
        step("f3", 3'd1, 1'b1, 1'b1, 1'b0, 8'hFD);
        step("f4", 3'd1, 1'b0, 1'b1, 1'b0, 8'hFF);
        step("f5", 3'd1, 1'b0, 1'b0, 1'b1, 8'hFF);
        step("f6", 3'd1, 1'b0, 1'b0, 1'b0, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
